// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID/EXE pipeline register of the five-stage ARM core.
// Captures decoded control, operands and PC for one cycle, with freeze (hold),
// flush (bubble insertion) and a valid bit that gates control on bubbles.
//
// Optional feature macro: FORWARDING_EN adds src1/src2 register-index fields.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   freeze                   hold all outputs
//   flush                    replace the incoming instruction with a bubble
//   valid_in / valid_out     real-instruction marker
//   pc, execute_command, mem_read, mem_write, wb_enable, immediate,
//   branch_taken, status_write_enable, val_rn, val_rm, shift_operand,
//   signed_imm_24, dest, carry (and src1, src2 with FORWARDING_EN)
//                            *_in sampled on clk rise, *_out registered copy
module id_exe_stage_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        flush,
   input  logic        valid_in,
   input  logic [31:0] pc_in,
   input  logic [3:0]  execute_command_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic        wb_enable_in,
   input  logic        immediate_in,
   input  logic        branch_taken_in,
   input  logic        status_write_enable_in,
   input  logic [31:0] val_rn_in,
   input  logic [31:0] val_rm_in,
   input  logic [11:0] shift_operand_in,
   input  logic [23:0] signed_imm_24_in,
   input  logic [3:0]  dest_in,
   input  logic        carry_in,
`ifdef FORWARDING_EN
   input  logic [3:0]  src1_in,
   input  logic [3:0]  src2_in,
   output logic [3:0]  src1_out,
   output logic [3:0]  src2_out,
`endif
   output logic [31:0] pc_out,
   output logic [3:0]  execute_command_out,
   output logic        mem_read_out,
   output logic        mem_write_out,
   output logic        wb_enable_out,
   output logic        immediate_out,
   output logic        branch_taken_out,
   output logic        status_write_enable_out,
   output logic [31:0] val_rn_out,
   output logic [31:0] val_rm_out,
   output logic [11:0] shift_operand_out,
   output logic [23:0] signed_imm_24_out,
   output logic [3:0]  dest_out,
   output logic        carry_out,
   output logic        valid_out
);

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned REG_W   = 4;
   localparam int unsigned CMD_W   = 4;
   localparam int unsigned SHIFT_W = 12;
   localparam int unsigned IMM_W   = 24;

   // Side-effecting control fields; forced to zero on bubbles and flushes
   typedef struct packed {
      logic [CMD_W-1:0] execute_command;
      logic             mem_read;
      logic             mem_write;
      logic             wb_enable;
      logic             immediate;
      logic             branch_taken;
      logic             status_write_enable;
   } ctrl_t;

   // Datapath fields; loaded even for bubbles, cleared only by flush
   typedef struct packed {
      logic [DATA_W-1:0]  pc;
      logic [DATA_W-1:0]  val_rn;
      logic [DATA_W-1:0]  val_rm;
      logic [SHIFT_W-1:0] shift_operand;
      logic [IMM_W-1:0]   signed_imm_24;
      logic [REG_W-1:0]   dest;
      logic               carry;
`ifdef FORWARDING_EN
      logic [REG_W-1:0]   src1;
      logic [REG_W-1:0]   src2;
`endif
   } data_t;

   ctrl_t ctrl_in_c, ctrl_d, ctrl_q;
   data_t data_in_c, data_d, data_q;
   logic  valid_d, valid_q;

   // Gather the incoming fields
   assign ctrl_in_c = {execute_command_in, mem_read_in, mem_write_in, wb_enable_in,
                       immediate_in, branch_taken_in, status_write_enable_in};
`ifdef FORWARDING_EN
   assign data_in_c = {pc_in, val_rn_in, val_rm_in, shift_operand_in,
                       signed_imm_24_in, dest_in, carry_in, src1_in, src2_in};
`else
   assign data_in_c = {pc_in, val_rn_in, val_rm_in, shift_operand_in,
                       signed_imm_24_in, dest_in, carry_in};
`endif

   // Next state: flush beats freeze beats load
   always_comb begin
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      valid_d = valid_q;
      if (flush) begin
         ctrl_d  = '0;
         data_d  = '0;
         valid_d = 1'b0;
      end else if (!freeze) begin
         valid_d = valid_in;
         data_d  = data_in_c;
         // A bubble must never carry side-effecting control downstream
         ctrl_d  = valid_in ? ctrl_in_c : '0;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign execute_command_out     = ctrl_q.execute_command;
   assign mem_read_out            = ctrl_q.mem_read;
   assign mem_write_out           = ctrl_q.mem_write;
   assign wb_enable_out           = ctrl_q.wb_enable;
   assign immediate_out           = ctrl_q.immediate;
   assign branch_taken_out        = ctrl_q.branch_taken;
   assign status_write_enable_out = ctrl_q.status_write_enable;
   assign pc_out                  = data_q.pc;
   assign val_rn_out              = data_q.val_rn;
   assign val_rm_out              = data_q.val_rm;
   assign shift_operand_out       = data_q.shift_operand;
   assign signed_imm_24_out       = data_q.signed_imm_24;
   assign dest_out                = data_q.dest;
   assign carry_out               = data_q.carry;
`ifdef FORWARDING_EN
   assign src1_out                = data_q.src1;
   assign src2_out                = data_q.src2;
`endif
   assign valid_out               = valid_q;

endmodule
